// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcodes, ALUOp codes and FSM state type for multicycle_control
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_MOV   = 6'h01;
  localparam logic [5:0] OP_SQU   = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_MULT  = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_NOP   = 3'd0;
  localparam logic [2:0] ALU_MOV   = 3'd1;
  localparam logic [2:0] ALU_SQU   = 3'd2;
  localparam logic [2:0] ALU_MUL   = 3'd3;
  localparam logic [2:0] ALU_ADD   = 3'd4;
  localparam logic [2:0] ALU_SUB   = 3'd5;
  localparam logic [2:0] ALU_RTYPE = 3'd7;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    EXEC   = 4'd3,
    MWAIT  = 4'd4,
    WB     = 4'd5,
    ADDR   = 4'd6,
    MEM    = 4'd7,
    MEMWB  = 4'd8,
    BRANCH = 4'd9,
    TRAP   = 4'd10
  } state_t;

  function automatic logic is_known_op(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_MOV, OP_SQU, OP_BEQ, OP_BNE,
      OP_ADDI, OP_MULT, OP_LW, OP_SW: is_known_op = 1'b1;
      default:                        is_known_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_delay_counter.sv
// rtl/ctrl_delay_counter.sv - loadable down-counter that times the MULT/SQU wait
module ctrl_delay_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         enable,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (enable && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS control FSM; optional MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN adds IllegalOp/TRAP
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int ALUOP_W  = 3,
  parameter int MULT_LAT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         OP,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               IorD,
  output logic               RegDst,
  output logic               ALUSrc,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               BranchEQ,
  output logic               BranchNE,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               Busy,
  output logic               InstrDone
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
  ,
  output logic               IllegalOp
`endif
);

  localparam int CNT_W = $clog2(MULT_LAT + 1);

  state_t     state, state_d;
  logic [5:0] op_q;
  logic [2:0] alu_code;
  logic       cnt_load, cnt_done;

  // counter is armed in DECODE so MWAIT runs exactly MULT_LAT cycles
  assign cnt_load = (state == DECODE) && ((OP == OP_MULT) || (OP == OP_SQU));

  ctrl_delay_counter #(.W(CNT_W)) u_delay (
    .clk    (clk),
    .rst_n  (reset),
    .load   (cnt_load),
    .value  (CNT_W'(MULT_LAT - 1)),
    .enable (state == MWAIT),
    .done   (cnt_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      op_q  <= '0;
    end else begin
      state <= state_d;
      if (state == DECODE) begin
        op_q <= OP;
      end
    end
  end

`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      illegal_q <= 1'b0;
    end else if ((state == DECODE) && !is_known_op(OP)) begin
      illegal_q <= 1'b1;
    end
  end

  assign IllegalOp = illegal_q;
`endif

  always_comb begin
    state_d = state;
    case (state)
      IDLE:   state_d = FETCH;
      FETCH:  state_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (OP)
          OP_RTYPE, OP_ADDI, OP_MOV: state_d = EXEC;
          OP_LW, OP_SW:              state_d = ADDR;
          OP_BEQ, OP_BNE:            state_d = BRANCH;
          OP_MULT, OP_SQU:           state_d = MWAIT;
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
          default:                   state_d = TRAP;
`else
          default:                   state_d = FETCH;
`endif
        endcase
      end
      EXEC:   state_d = WB;
      MWAIT:  state_d = cnt_done ? WB : MWAIT;
      WB:     state_d = FETCH;
      ADDR:   state_d = MEM;
      MEM: begin
        if (mem_ready) begin
          state_d = (op_q == OP_SW) ? FETCH : MEMWB;
        end
      end
      MEMWB:  state_d = FETCH;
      BRANCH: state_d = FETCH;
      TRAP:   state_d = TRAP;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    IorD      = 1'b0;
    RegDst    = 1'b0;
    ALUSrc    = 1'b0;
    MemtoReg  = 1'b0;
    RegWrite  = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    BranchEQ  = 1'b0;
    BranchNE  = 1'b0;
    InstrDone = 1'b0;
    alu_code  = ALU_NOP;
    case (state)
      FETCH: begin
        MemRead  = 1'b1;
        alu_code = ALU_ADD;
        PCWrite  = mem_ready;
        IRWrite  = mem_ready;
      end
      DECODE: begin
`ifndef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
        InstrDone = !is_known_op(OP);
`endif
      end
      EXEC: begin
        case (op_q)
          OP_ADDI: begin
            ALUSrc   = 1'b1;
            alu_code = ALU_ADD;
          end
          OP_MOV: begin
            ALUSrc   = 1'b1;
            alu_code = ALU_MOV;
          end
          default: alu_code = ALU_RTYPE;
        endcase
      end
      MWAIT: alu_code = (op_q == OP_SQU) ? ALU_SQU : ALU_MUL;
      WB: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        RegDst    = (op_q != OP_ADDI);
      end
      ADDR: begin
        ALUSrc   = 1'b1;
        alu_code = ALU_ADD;
      end
      MEM: begin
        IorD = 1'b1;
        if (op_q == OP_SW) begin
          MemWrite  = 1'b1;
          InstrDone = mem_ready;
        end else begin
          MemRead = 1'b1;
        end
      end
      MEMWB: begin
        RegWrite  = 1'b1;
        MemtoReg  = 1'b1;
        InstrDone = 1'b1;
      end
      BRANCH: begin
        alu_code  = ALU_SUB;
        BranchEQ  = (op_q == OP_BEQ);
        BranchNE  = (op_q == OP_BNE);
        InstrDone = 1'b1;
      end
      default: ;
    endcase
  end

  assign ALUOp = ALUOP_W'(alu_code);
  assign Busy  = (state != IDLE) && (state != FETCH);

endmodule
